mem_debug_reader: RTL and testbench

MEM_DEBUG_READER -- requirements
Module: mem_debug_reader

---
 rtl/mem_debug_reader_pkg.sv | 18 +
 rtl/mem_debug_reader_if.sv | 18 +
 rtl/mem_debug_reader_word_serializer.sv | 42 ++++
 rtl/mem_debug_reader.sv | 123 ++++++++++++
 tb/tb_mem_debug_reader.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mem_debug_reader_pkg.sv
// Shared types and constants for the memory debug reader.
// Define DBG_CHECKSUM_EN to add the trailing mod-256 checksum byte (state CHK).
package mem_debug_reader_pkg;

  localparam int BYTE_W = 8;

`ifdef DBG_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SEND, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SEND, DONE} state_t;
`endif

  // Width of the word index; a single-word memory still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_debug_reader_if.sv
// Debug read port towards the data memory plus the byte stream towards the UART TX.
interface mem_debug_reader_if #(parameter int NBITS = 32);
  logic [NBITS-1:0] o_DebugDireccion;
  logic [NBITS-1:0] i_DebugDato;
  logic [7:0]       o_TxDato;
  logic             o_TxValid;
  logic             i_TxReady;

  modport master (
    output o_DebugDireccion, o_TxDato, o_TxValid,
    input  i_DebugDato, i_TxReady
  );

  modport slave (
    input  o_DebugDireccion, o_TxDato, o_TxValid,
    output i_DebugDato, i_TxReady
  );
endinterface

// File: rtl/mem_debug_reader_word_serializer.sv
// Holds one memory word and presents it one byte at a time, LSB first,
// advancing on each valid/ready transfer and flagging the final byte.
module word_serializer
  import mem_debug_reader_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [NBITS-1:0] word_in,
  input  logic             valid,
  input  logic             ready,
  output logic [7:0]       byte_out,
  output logic             last
);

  localparam int NBYTES = NBITS / BYTE_W;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NBITS-1:0] word;
  logic [CW-1:0]    cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  // NOTE: the word register is reset too, so an aborted dump leaves no partial data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else if (load) begin
      word <= word_in;
      cnt  <= '0;
    end else if (valid && ready && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last     = (cnt == CW'(NBYTES - 1));
  assign byte_out = word[BYTE_W*cnt +: BYTE_W];

endmodule

// File: rtl/mem_debug_reader.sv
// Dumps CELDAS words of data memory through the debug read port as a byte stream.
// Define DBG_CHECKSUM_EN to append a mod-256 checksum byte after the last word.
module mem_debug_reader
  import mem_debug_reader_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_Busy,
  output logic                o_Done,
  mem_debug_reader_if.master  bus
);

  localparam int             IW       = idx_width(CELDAS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(CELDAS - 1);

  state_t           state;
  logic [IW-1:0]    index;
  logic [NBITS-1:0] addr;
  logic             tx_valid;
  logic             busy;
  logic             done;
  logic [7:0]       ser_byte;
  logic             ser_last;
  logic             xfer;

  assign xfer = tx_valid && bus.i_TxReady;

  word_serializer #(.NBITS(NBITS)) u_ser (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .load     (state == FETCH),
    .word_in  (bus.i_DebugDato),
    .valid    (tx_valid && (state == SEND)),
    .ready    (bus.i_TxReady),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

`ifdef DBG_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                            sum <= '0;
    else if (state == IDLE && i_start)       sum <= '0;
    else if (state == SEND && xfer)          sum <= sum + ser_byte;
  end

  assign bus.o_TxDato = !tx_valid ? 8'h00 : (state == CHK) ? sum : ser_byte;
`else
  assign bus.o_TxDato = tx_valid ? ser_byte : 8'h00;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      index    <= '0;
      addr     <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            index <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          addr  <= NBITS'(index);
          state <= FETCH;
        end
        FETCH: begin
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (xfer && ser_last) begin
            if (index != LAST_IDX) begin
              index    <= index + 1'b1;
              tx_valid <= 1'b0;
              state    <= LOAD;
            end else begin
`ifdef DBG_CHECKSUM_EN
              state    <= CHK;
`else
              tx_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
`endif
            end
          end
        end
`ifdef DBG_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_DebugDireccion = addr;
  assign bus.o_TxValid        = tx_valid;
  assign o_Busy               = busy;
  assign o_Done               = done;

endmodule

// File: tb/tb_mem_debug_reader.sv
// Directed bench for mem_debug_reader: memory word k holds k, 32-bit words, 16 words.
module tb_mem_debug_reader;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_start;
  logic o_Busy;
  logic o_Done;

  mem_debug_reader_if #(.NBITS(32)) bus ();

  mem_debug_reader #(.NBITS(32), .CELDAS(16)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: word k holds the value k.
  assign bus.i_DebugDato = bus.o_DebugDireccion;

`ifdef DBG_CHECKSUM_EN
  localparam int EXP_BYTES  = 65;
  localparam int EXP_CYCLES = 97;
`else
  localparam int EXP_BYTES  = 64;
  localparam int EXP_CYCLES = 96;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] bytes[$];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Record any transfer that the coming edge will perform, then move to just after it.
  task automatic step();
    if (bus.o_TxValid && bus.i_TxReady) bytes.push_back(bus.o_TxDato);
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    if (i == 64) return 8'h78;
    return (i % 4 == 0) ? 8'(i / 4) : 8'h00;
  endfunction

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, bytes.size(), EXP_BYTES);
    n = (bytes.size() < EXP_BYTES) ? bytes.size() : EXP_BYTES;
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), bytes[i], exp_byte(i));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"},  bus.o_DebugDireccion, 32'h0);
    check({tag, "_dato"},  bus.o_TxDato, 32'h0);
    check({tag, "_valid"}, bus.o_TxValid, 32'h0);
    check({tag, "_busy"},  o_Busy, 32'h0);
    check({tag, "_done"},  o_Done, 32'h0);
  endtask

  // Runs one dump from a start pulse; optional stall, re-start pulse and reset abort.
  task automatic run_dump(input string tag, input int stall_at, input int restart_at,
                          input int reset_word, input int exp_cycles);
    int cycles = 0;
    int dones  = 0;
    bit stalled = 0;
    bit aborted = 0;
    bytes.delete();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check({tag, "_busy_load"}, o_Busy, 32'h1);
    while (!o_Done && cycles < 400) begin
      if (reset_word >= 0 && bus.o_TxValid && bus.o_DebugDireccion == 32'(reset_word)) begin
        i_reset = 1'b0;
        #1;
        check_outputs_zero({tag, "_abort"});
        aborted = 1;
        break;
      end
      if (stall_at >= 0 && !stalled && bytes.size() == stall_at && bus.o_TxValid) begin
        bus.i_TxReady = 1'b0;
        repeat (3) begin
          step();
          cycles++;
          check({tag, "_stall_dato"}, bus.o_TxDato, 32'h05);
          check({tag, "_stall_valid"}, bus.o_TxValid, 32'h1);
        end
        bus.i_TxReady = 1'b1;
        stalled = 1;
      end
      if (cycles == restart_at) i_start = 1'b1;
      step();
      i_start = 1'b0;
      cycles++;
    end
    if (!aborted) begin
      check({tag, "_cycles"}, cycles, exp_cycles);
      if (o_Done) dones++;
      check({tag, "_busy_done"}, o_Busy, 32'h1);
      step();
      if (o_Done) dones++;
      check({tag, "_done_pulses"}, dones, 32'h1);
      check({tag, "_busy_idle"}, o_Busy, 32'h0);
      check_stream(tag);
    end
  endtask

  initial begin
    i_reset       = 1'b1;
    i_start       = 1'b0;
    bus.i_TxReady = 1'b1;
    #2 i_reset = 1'b0;
    #1;
    check_outputs_zero("reset");
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    step();
    check_outputs_zero("idle");

    run_dump("plain", -1, -1, -1, EXP_CYCLES);
    step();
    run_dump("stall", 20, -1, -1, EXP_CYCLES + 3);
    step();
    run_dump("restart", -1, 40, -1, EXP_CYCLES);
    step();
    run_dump("abort", -1, -1, 7, 0);
    step();
    step();
    check_outputs_zero("held");
    i_reset = 1'b1;
    step();
    run_dump("after_reset", -1, -1, -1, EXP_CYCLES);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
